// File: rtl/pipe_add_acc.sv
// pipe_add_acc: two-stage valid/ready add/subtract/accumulate pipeline.
// Stage 1 registers the operands and operation. Stage 2 computes the result,
// holds it for the consumer and commits the internal accumulator.
// Optional feature: define PIPE_ADD_SAT_EN to clamp signed overflows of
// ADD, SUB and ACC to the most positive or most negative value. Without it,
// results wrap and overflow is only reported.
module pipe_add_acc #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int W = DATAWIDTH;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_ACC  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    logic         en;
    logic         s1_valid;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    mode_t        s1_mode;
    logic [W-1:0] acc;

    logic [W:0]   wide;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_ovf;
    logic         first_sign;

    // The whole pipe advances together. It stalls only when a result is
    // waiting and the consumer is not taking it.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage-2 arithmetic on the stage-1 operands. The extra top bit of the
    // wide sum is the carry, or the no-borrow flag for subtraction. ACC reads
    // the committed accumulator, which the previous op updated at the edge
    // where that op entered stage 2, so back-to-back ACCs need no forwarding.
    always_comb begin
        wide       = '0;
        res_ovf    = 1'b0;
        first_sign = s1_a[W-1];
        case (s1_mode)
            MODE_ADD: begin
                wide    = {1'b0, s1_a} + {1'b0, s1_b};
                res_ovf = (s1_a[W-1] == s1_b[W-1]) && (wide[W-1] != s1_a[W-1]);
            end
            MODE_SUB: begin
                wide    = {1'b0, s1_a} + {1'b0, ~s1_b} + {{W{1'b0}}, 1'b1};
                res_ovf = (s1_a[W-1] != s1_b[W-1]) && (wide[W-1] != s1_a[W-1]);
            end
            MODE_ACC: begin
                wide       = {1'b0, acc} + {1'b0, s1_a};
                first_sign = acc[W-1];
                res_ovf    = (acc[W-1] == s1_a[W-1]) && (wide[W-1] != acc[W-1]);
            end
            default: begin
                wide = {1'b0, s1_a};
            end
        endcase
        res_sum  = wide[W-1:0];
        res_cout = wide[W];
`ifdef PIPE_ADD_SAT_EN
        if (res_ovf) begin
            res_sum = first_sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
    end

    // Pipeline registers and accumulator. A bubble moves through stage 2
    // without touching the held result or the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_mode   <= MODE_ADD;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            acc       <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_a      <= a;
            s1_b      <= b;
            s1_mode   <= mode_t'(mode);
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= res_sum;
                cout <= res_cout;
                ovf  <= res_ovf;
                if (s1_mode == MODE_ACC || s1_mode == MODE_LOAD) begin
                    acc <= res_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_add_acc.sv
// tb_pipe_add_acc: randomized and directed bench for pipe_add_acc.
// Expected results come from a signed/unsigned integer model of the
// operations and a queue that records the order of accepted inputs.
module tb_pipe_add_acc;

    localparam int W     = 8;
    localparam int FULL  = 1 << W;
    localparam int SMAX  = (1 << (W - 1)) - 1;
    localparam int SMIN  = -(1 << (W - 1));
    localparam logic [1:0] M_ADD  = 2'b00;
    localparam logic [1:0] M_SUB  = 2'b01;
    localparam logic [1:0] M_ACC  = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   mode;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         out_valid;
    logic         out_ready;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t obs_q[$];
    int   macc = 0;

    pipe_add_acc #(.DATAWIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .a(a),
        .b(b),
        .mode(mode),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .sum(sum),
        .cout(cout),
        .ovf(ovf),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one accepted operation, evaluated with plain integer
    // arithmetic and range checks on the signed interpretation.
    function automatic res_t model(input logic [1:0] m, input logic [W-1:0] x, input logic [W-1:0] y);
        res_t r;
        int ux, uy, sx, sy, sacc, u, s, clamp;
        ux   = int'(x);
        uy   = int'(y);
        sx   = (ux > SMAX) ? ux - FULL : ux;
        sy   = (uy > SMAX) ? uy - FULL : uy;
        sacc = (macc > SMAX) ? macc - FULL : macc;
        r    = '0;
        if (m == M_LOAD) begin
            r.sum = x;
            macc  = ux;
            return r;
        end
        if (m == M_ADD) begin
            u = ux + uy;
            s = sx + sy;
            r.cout = (u >= FULL);
        end else if (m == M_SUB) begin
            u = ux - uy;
            s = sx - sy;
            r.cout = (ux >= uy);
        end else begin
            u = macc + ux;
            s = sacc + sx;
            r.cout = (u >= FULL);
        end
        r.ovf = (s > SMAX) || (s < SMIN);
        r.sum = u[W-1:0];
`ifdef PIPE_ADD_SAT_EN
        if (r.ovf) begin
            clamp = (s > SMAX) ? SMAX : SMIN;
            r.sum = clamp[W-1:0];
        end
`else
        clamp = 0;
`endif
        if (m == M_ACC) macc = int'(r.sum);
        return r;
    endfunction

    // One clock cycle: drive inputs, note both handshakes mid-cycle, then
    // advance to just after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic [1:0] m, input logic ordy, output logic accepted);
        res_t o;
        in_valid  = v;
        a         = ia;
        b         = ib;
        mode      = m;
        out_ready = ordy;
        @(negedge clk);
        if (out_valid && out_ready) begin
            o.sum  = sum;
            o.cout = cout;
            o.ovf  = ovf;
            obs_q.push_back(o);
        end
        accepted = in_valid && in_ready;
        if (accepted) exp_q.push_back(model(m, ia, ib));
        @(posedge clk);
        #1;
    endtask

    // Idle cycles with the consumer ready, letting everything in flight drain.
    task automatic flush();
        logic acc_unused;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, '0, M_ADD, 1'b1, acc_unused);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = M_ADD; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_handshake out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        checks++;
        if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs sum=%h cout=%b ovf=%b want 00/0/0", sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_vectors();
        logic acc;
        res_t o, e;
        applyStimulus(1'b1, 8'hFF, 8'h01, M_ADD, 1'b1, acc);
        applyStimulus(1'b0, 8'h00, 8'h00, M_ADD, 1'b1, acc);
        checks++;
        if (out_valid !== 1'b1 || sum !== 8'h00 || cout !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_ff_01 valid=%b sum=%h cout=%b ovf=%b want 1/00/1/0", out_valid, sum, cout, ovf);
        end
        applyStimulus(1'b1, 8'h80, 8'h01, M_SUB, 1'b1, acc);
        applyStimulus(1'b0, 8'h00, 8'h00, M_ADD, 1'b1, acc);
`ifdef PIPE_ADD_SAT_EN
        e.sum = 8'h80;
`else
        e.sum = 8'h7F;
`endif
        checks++;
        if (out_valid !== 1'b1 || sum !== e.sum || ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sub_80_01 valid=%b sum=%h ovf=%b want 1/%h/1", out_valid, sum, ovf, e.sum);
        end
        flush();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL vectors_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL vectors_result got %h want %h", o, e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic acc;
        res_t o, e;
        logic [W-1:0] want [3];
        want[0] = 8'h10; want[1] = 8'h15; want[2] = 8'h18;
        applyStimulus(1'b1, 8'h10, 8'h00, M_LOAD, 1'b1, acc);
        applyStimulus(1'b1, 8'h05, 8'h00, M_ACC, 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || sum !== want[i]) begin
                errors++;
                $display("[TB] FAIL b2b_step%0d valid=%b sum=%h want 1/%h", i, out_valid, sum, want[i]);
            end
            if (i == 0) applyStimulus(1'b1, 8'h03, 8'h00, M_ACC, 1'b1, acc);
            else applyStimulus(1'b0, 8'h00, 8'h00, M_ADD, 1'b1, acc);
        end
        checks++;
        if (dut.acc !== 8'h18) begin
            errors++;
            $display("[TB] FAIL b2b_acc got %h want 18", dut.acc);
        end
        flush();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL b2b_result got %h want %h", o, e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_stall();
        logic acc;
        int   taken;
        res_t o, e;
        logic [W-1:0] held;
        applyStimulus(1'b1, 8'h01, 8'h02, M_ADD, 1'b1, acc);
        applyStimulus(1'b1, 8'h03, 8'h04, M_ADD, 1'b1, acc);
        held = exp_q[0].sum;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 8'h05, 8'h06, M_ADD, 1'b0, acc);
            checks++;
            if (acc !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== held) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d acc=%b in_ready=%b valid=%b sum=%h want 0/0/1/%h",
                         k, acc, in_ready, out_valid, sum, held);
            end
        end
        taken = 0;
        for (int k = 0; k < 5 && taken == 0; k++) begin
            applyStimulus(1'b1, 8'h05, 8'h06, M_ADD, 1'b1, acc);
            if (acc) taken++;
        end
        checks++;
        if (taken != 1) begin
            errors++;
            $display("[TB] FAIL stall_release accepted=%0d want 1", taken);
        end
        flush();
        checks++;
        if (obs_q.size() != 3 || exp_q.size() != 3) begin
            errors++;
            $display("[TB] FAIL stall_count got %0d want 3", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL stall_order got %h want %h", o, e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        logic         acc, pv, ordy;
        logic [W-1:0] pa, pb;
        logic [1:0]   pm;
        res_t         o, e;
        pv = 1'b0; pa = '0; pb = '0; pm = M_ADD;
        for (int i = 0; i < 400; i++) begin
            if (!pv) begin
                pv = ($urandom_range(0, 3) != 0);
                pa = W'($urandom());
                pb = W'($urandom());
                pm = 2'($urandom());
            end
            ordy = ($urandom_range(0, 2) != 0);
            applyStimulus(pv, pa, pb, pm, ordy, acc);
            if (acc || !pv) pv = 1'b0;
        end
        flush();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL random_result got %h want %h", o, e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        logic acc;
        res_t o, e;
        applyStimulus(1'b1, 8'h40, 8'h00, M_LOAD, 1'b1, acc);
        flush();
        obs_q.delete();
        exp_q.delete();
        applyStimulus(1'b1, 8'h01, 8'h00, M_ACC, 1'b1, acc);
        applyStimulus(1'b1, 8'h02, 8'h00, M_ACC, 1'b1, acc);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dut.acc !== 8'h00 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_clear valid=%b acc=%h in_ready=%b want 0/00/1", out_valid, dut.acc, in_ready);
        end
        exp_q.delete();
        obs_q.delete();
        macc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 8'h02, 8'h00, M_ACC, 1'b1, acc);
        applyStimulus(1'b0, 8'h00, 8'h00, M_ADD, 1'b1, acc);
        checks++;
        if (out_valid !== 1'b1 || sum !== 8'h02) begin
            errors++;
            $display("[TB] FAIL midreset_acc valid=%b sum=%h want 1/02", out_valid, sum);
        end
        flush();
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL midreset_count got %0d want 1", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL midreset_result got %h want %h", o, e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_add_acc.md
PIPE_ADD_ACC -- requirements
Module: pipe_add_acc

Interface
REQ-001 Parameter DATAWIDTH, default 8, operand/result width in bits (minimum 2).
REQ-002 Clk  input  1  clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset, asynchronous, active-low.
REQ-004 a  input  DATAWIDTH  operand A.
REQ-005 b  input  DATAWIDTH  operand B (ignored in ACC and LOAD modes).
REQ-006 mode  input  2  operation: 00 ADD (a+b), 01 SUB (a-b), 10 ACC (acc+a), 11 LOAD (acc=a).
REQ-007 in_valid  input  1  a/b/mode valid this cycle.
REQ-008 in_ready  output  1  block accepts input this cycle.
REQ-009 sum  output  DATAWIDTH  result.
REQ-010 cout  output  1  unsigned carry out (ADD/ACC); borrow-not (SUB); 0 for LOAD.
REQ-011 ovf  output  1  two's-complement signed overflow of the operation.
REQ-012 out_valid  output  1  sum/cout/ovf valid.
REQ-013 out_ready  input  1  downstream accepts result.

Function
REQ-014 Transfer in: in_valid && in_ready on a rising edge; transfer out: out_valid && out_ready.
REQ-015 Two register stages: S1 captures a, b, mode, valid; S2 computes and holds the result; latency 2 cycles from input transfer to out_valid, when not stalled.
REQ-016 Global enable en = !out_valid || out_ready; in_ready = en, combinational, with no dependence on in_valid.
REQ-017 When en = 0, S1, S2, accumulator and all outputs hold their values.
REQ-018 When en = 1, S2 loads from S1 (including S1 valid bit) and S1 loads the input with valid = in_valid.
REQ-019 Bubbles (S1 valid = 0) propagate as out_valid = 0 and do not alter acc, sum, cout or ovf.
REQ-020 Internal register acc, DATAWIDTH wide, updates only when a valid ACC or LOAD op enters S2: ACC sets acc = sum result, LOAD sets acc = a.
REQ-021 For ADD/SUB, acc is unchanged; sum = a+b or a-b, computed internally at DATAWIDTH+1 bits; cout = bit DATAWIDTH (SUB: 1 means no borrow).
REQ-022 ovf = operand sign bits are equal (SUB: differ) and result sign differs from operand A (or acc for ACC).
REQ-023 Back-to-back ACC ops are hazard-free: each uses the acc committed by the previous op.
REQ-024 Input held while in_ready = 0 is not captured; the source keeps it stable until transfer.

Reset
REQ-025 Rst low asynchronously clears S1/S2 valid bits, acc, sum, cout and ovf to 0; out_valid = 0, and in_ready = 1 while in reset.
REQ-026 Reset mid-operation discards all in-flight results; the first valid output after Rst rises comes from an input accepted after reset.

Configuration
REQ-027 Macro PIPE_ADD_SAT_EN defined: ADD, SUB and ACC treat operands as signed; on ovf, sum (and acc for ACC) clamps to 2^(DATAWIDTH-1)-1 on positive overflow or -2^(DATAWIDTH-1) on negative overflow; ovf is still asserted.
REQ-028 PIPE_ADD_SAT_EN undefined: results wrap modulo 2^DATAWIDTH; ovf is reported only.

Verification (DATAWIDTH=8)
REQ-029 ADD a=0xFF b=0x01, out_ready=1 -> two cycles later out_valid=1, sum=0x00, cout=1, ovf=0.
REQ-030 SUB a=0x80 b=0x01 -> sum=0x7F, ovf=1 without the macro; sum=0x80, ovf=1 with PIPE_ADD_SAT_EN.
REQ-031 LOAD a=0x10, then ACC a=0x05 and ACC a=0x03 back-to-back -> sums 0x10, 0x15, 0x18 on consecutive cycles; acc=0x18.
REQ-032 out_ready=0 while out_valid=1 for 3 cycles -> in_ready=0, sum held, no input lost; out_ready=1 -> remaining results drain in order.
REQ-033 Rst asserted with two ACC ops in flight -> out_valid=0 and acc=0 immediately; after release, ACC a=0x02 -> sum=0x02.
